// File: rtl/riscv32_cpu.sv
// riscv32_cpu: single-cycle RV32I subset core with a debug readout port.
// Define RISCV32_CPU_MUL_EN to add the MUL instruction.
module riscv32_cpu (
    input  logic        iCLK,
    input  logic        iRST,
    output logic        oROM_CE,
    output logic        oROM_RD,
    output logic [7:0]  oROM_ADDR,
    input  logic [31:0] iROM_DATA,
    output logic        oRAM_CE,
    output logic        oRAM_RD,
    output logic        oRAM_WR,
    output logic [7:0]  oRAM_ADDR,
    output logic [31:0] oRAM_DATA,
    input  logic [31:0] iRAM_DATA,
    input  logic [1:0]  iMODE,
    input  logic [7:0]  iSW,
    output logic [31:0] oREG32
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] nextPc;
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] immI;
    logic [31:0] immS;
    logic [31:0] immB;
    logic [31:0] immU;
    logic [31:0] immJ;
    logic [31:0] rs1Val;
    logic [31:0] rs2Val;

    logic        isLui;
    logic        isAuipc;
    logic        isJal;
    logic        isJalr;
    logic        isBranch;
    logic        isLw;
    logic        isSw;
    logic        isOpImm;
    logic        isOp;
    logic        isMul;
    logic        immAlt;
    logic        opLegal;

    logic [31:0] aluRes;
    logic [31:0] memAddr;
    logic [31:0] wbData;
    logic [31:0] mulRes;
    logic        wbEn;
    logic        ramRd;
    logic        ramWr;
    logic        unusedBits;

    assign opcode = iROM_DATA[6:0];
    assign rd     = iROM_DATA[11:7];
    assign funct3 = iROM_DATA[14:12];
    assign rs1    = iROM_DATA[19:15];
    assign rs2    = iROM_DATA[24:20];
    assign funct7 = iROM_DATA[31:25];

    assign immI = {{20{iROM_DATA[31]}}, iROM_DATA[31:20]};
    assign immS = {{20{iROM_DATA[31]}}, iROM_DATA[31:25], iROM_DATA[11:7]};
    assign immB = {{19{iROM_DATA[31]}}, iROM_DATA[31], iROM_DATA[7],
                   iROM_DATA[30:25], iROM_DATA[11:8], 1'b0};
    assign immU = {iROM_DATA[31:12], 12'd0};
    assign immJ = {{11{iROM_DATA[31]}}, iROM_DATA[31], iROM_DATA[19:12],
                   iROM_DATA[20], iROM_DATA[30:21], 1'b0};

    assign rs1Val  = regs[rs1];
    assign rs2Val  = regs[rs2];
    assign pcPlus4 = pc + 32'd4;

`ifdef RISCV32_CPU_MUL_EN
    assign isMul  = (funct7 == 7'b0000001) && (funct3 == 3'b000);
    assign mulRes = rs1Val * rs2Val;
`else
    assign isMul  = 1'b0;
    assign mulRes = 32'd0;
`endif

    // Shift-immediate forms must carry a valid funct7; other OP-IMM forms use it as immediate.
    always_comb begin
        immAlt  = 1'b0;
        opLegal = 1'b0;
        unique case (funct3)
            3'b001: opLegal = (funct7 == 7'b0000000);
            3'b101: begin
                opLegal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                immAlt  = funct7[5];
            end
            default: opLegal = 1'b1;
        endcase
    end

    assign isLui    = (opcode == OP_LUI);
    assign isAuipc  = (opcode == OP_AUIPC);
    assign isJal    = (opcode == OP_JAL);
    assign isJalr   = (opcode == OP_JALR) && (funct3 == 3'b000);
    assign isBranch = (opcode == OP_BR) && (funct3[2:1] != 2'b01);
    assign isLw     = (opcode == OP_LOAD) && (funct3 == 3'b010);
    assign isSw     = (opcode == OP_STORE) && (funct3 == 3'b010);
    assign isOpImm  = (opcode == OP_IMM) && opLegal;
    assign isOp     = (opcode == OP_REG) && (
                          (funct7 == 7'b0000000) ||
                          (funct7 == 7'b0100000 &&
                           (funct3 == 3'b000 || funct3 == 3'b101)) ||
                          isMul);

    function automatic logic [31:0] alu(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  f3,
        input logic        alt
    );
        logic [31:0] r;
        unique case (f3)
            3'b000: r = alt ? a - b : a + b;
            3'b001: r = a << b[4:0];
            3'b010: r = {31'd0, $signed(a) < $signed(b)};
            3'b011: r = {31'd0, a < b};
            3'b100: r = a ^ b;
            3'b101: r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic brCond(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  f3
    );
        logic t;
        unique case (f3)
            3'b000: t = (a == b);
            3'b001: t = (a != b);
            3'b100: t = ($signed(a) < $signed(b));
            3'b101: t = ($signed(a) >= $signed(b));
            3'b110: t = (a < b);
            3'b111: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    always_comb begin
        wbEn    = 1'b0;
        wbData  = 32'd0;
        nextPc  = pcPlus4;
        ramRd   = 1'b0;
        ramWr   = 1'b0;
        aluRes  = 32'd0;
        memAddr = 32'd0;
        unique case (1'b1)
            isLui: begin
                aluRes = immU;
                wbEn   = 1'b1;
                wbData = aluRes;
            end
            isAuipc: begin
                aluRes = pc + immU;
                wbEn   = 1'b1;
                wbData = aluRes;
            end
            isJal: begin
                aluRes = pc + immJ;
                nextPc = aluRes;
                wbEn   = 1'b1;
                wbData = pcPlus4;
            end
            isJalr: begin
                aluRes = (rs1Val + immI) & 32'hFFFF_FFFE;
                nextPc = aluRes;
                wbEn   = 1'b1;
                wbData = pcPlus4;
            end
            isBranch: begin
                aluRes = pc + immB;
                if (brCond(rs1Val, rs2Val, funct3))
                    nextPc = aluRes;
            end
            isLw: begin
                memAddr = rs1Val + immI;
                aluRes  = memAddr;
                ramRd   = 1'b1;
                wbEn    = 1'b1;
                wbData  = iRAM_DATA;
            end
            isSw: begin
                memAddr = rs1Val + immS;
                aluRes  = memAddr;
                ramWr   = 1'b1;
            end
            isOpImm: begin
                aluRes = alu(rs1Val, immI, funct3, immAlt);
                wbEn   = 1'b1;
                wbData = aluRes;
            end
            isOp: begin
                aluRes = isMul ? mulRes : alu(rs1Val, rs2Val, funct3, funct7[5]);
                wbEn   = 1'b1;
                wbData = aluRes;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
        end else begin
            pc <= nextPc;
            if (wbEn && rd != 5'd0)
                regs[rd] <= wbData;
        end
    end

    assign oROM_CE   = ~iRST;
    assign oROM_RD   = ~iRST;
    assign oRAM_CE   = ~iRST;
    assign oRAM_RD   = ~iRST & ramRd;
    assign oRAM_WR   = ~iRST & ramWr;
    assign oROM_ADDR = iRST ? 8'd0 : pc[9:2];
    assign oRAM_ADDR = iRST ? 8'd0 : memAddr[9:2];
    assign oRAM_DATA = iRST ? 32'd0 : rs2Val;

    always_comb begin
        unique case (iMODE)
            2'b00: oREG32 = regs[iSW[4:0]];
            2'b01: oREG32 = pc;
            2'b10: oREG32 = iROM_DATA;
            default: oREG32 = aluRes;
        endcase
    end

    assign unusedBits = ^{memAddr[31:10], memAddr[1:0], iSW[7:5]};
endmodule

// File: tb/tb_riscv32_cpu.sv
// Directed testbench for riscv32_cpu with behavioural ROM and RAM.
module tb_riscv32_cpu;
    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        oROM_CE;
    logic        oROM_RD;
    logic [7:0]  oROM_ADDR;
    logic [31:0] iROM_DATA;
    logic        oRAM_CE;
    logic        oRAM_RD;
    logic        oRAM_WR;
    logic [7:0]  oRAM_ADDR;
    logic [31:0] oRAM_DATA;
    logic [31:0] iRAM_DATA;
    logic [1:0]  iMODE = 2'b00;
    logic [7:0]  iSW = 8'd0;
    logic [31:0] oREG32;

    logic [31:0] rom [256];
    logic [31:0] ram [256];
    int vecs = 0;
    int errs = 0;

    riscv32_cpu dut (
        .iCLK(iCLK), .iRST(iRST),
        .oROM_CE(oROM_CE), .oROM_RD(oROM_RD),
        .oROM_ADDR(oROM_ADDR), .iROM_DATA(iROM_DATA),
        .oRAM_CE(oRAM_CE), .oRAM_RD(oRAM_RD), .oRAM_WR(oRAM_WR),
        .oRAM_ADDR(oRAM_ADDR), .oRAM_DATA(oRAM_DATA),
        .iRAM_DATA(iRAM_DATA),
        .iMODE(iMODE), .iSW(iSW), .oREG32(oREG32)
    );

    always #5 iCLK = ~iCLK;

    assign iROM_DATA = rom[oROM_ADDR];
    assign iRAM_DATA = ram[oRAM_ADDR];

    always @(posedge iCLK)
        if (oRAM_WR) ram[oRAM_ADDR] <= oRAM_DATA;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] encI(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] encS(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] encJ(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] encU(input logic [31:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
        return {imm[19:0], rd, op};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [31:0] imm);
        return encI(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 256; i++) begin
            rom[i] = NOP;
            ram[i] = 32'd0;
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic restart();
        @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
    endtask

    task automatic peek(input logic [1:0] m, input logic [4:0] idx, output logic [31:0] v);
        iMODE = m;
        iSW = {3'd0, idx};
        #1;
        v = oREG32;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        clearRom();
        rom[0] = addi(5'd1, 5'd0, 32'd5);
        iRST = 1'b1;
        #2;
        vecs++;
        if ({oROM_CE, oROM_RD, oRAM_CE, oRAM_RD, oRAM_WR} !== 5'b00000) begin
            $display("FAIL reset_strobes: got %b want 00000",
                     {oROM_CE, oROM_RD, oRAM_CE, oRAM_RD, oRAM_WR});
            errs++;
        end
        vecs++;
        if (oROM_ADDR !== 8'd0 || oRAM_DATA !== 32'd0) begin
            $display("FAIL reset_addr_data: got %h/%h want 00/0", oROM_ADDR, oRAM_DATA);
            errs++;
        end
        peek(2'b01, 5'd0, v);
        vecs++;
        if (v !== 32'd0) begin
            $display("FAIL reset_pc: got %h want 0", v);
            errs++;
        end
        peek(2'b10, 5'd0, v);
        vecs++;
        if (v !== 32'h0050_0093) begin
            $display("FAIL reset_instr: got %h want 00500093", v);
            errs++;
        end
    endtask

    task automatic test_addi();
        logic [31:0] v;
        clearRom();
        rom[0] = addi(5'd1, 5'd0, 32'd5);
        rom[1] = addi(5'd2, 5'd1, 32'hFFFF_FFF9);
        restart();
        peek(2'b11, 5'd0, v);
        vecs++;
        if (v !== 32'd5 || oROM_CE !== 1'b1 || oRAM_CE !== 1'b1) begin
            $display("FAIL addi_alu: got %h ce=%b%b want 5 ce=11", v, oROM_CE, oRAM_CE);
            errs++;
        end
        step();
        step();
        peek(2'b00, 5'd1, v);
        vecs++;
        if (v !== 32'd5) begin
            $display("FAIL addi_x1: got %h want 5", v);
            errs++;
        end
        peek(2'b00, 5'd2, v);
        vecs++;
        if (v !== 32'hFFFF_FFFE) begin
            $display("FAIL addi_x2: got %h want fffffffe", v);
            errs++;
        end
        vecs++;
        if (oROM_ADDR !== 8'd2) begin
            $display("FAIL addi_romaddr: got %h want 02", oROM_ADDR);
            errs++;
        end
    endtask

    task automatic test_load_store();
        logic [31:0] v;
        clearRom();
        rom[0] = addi(5'd1, 5'd0, 32'h40);
        rom[1] = addi(5'd2, 5'd0, 32'h123);
        rom[2] = encS(32'd4, 5'd2, 5'd1, 3'b010);
        rom[3] = encI(32'd4, 5'd1, 3'b010, 5'd3, 7'b0000011);
        restart();
        step();
        step();
        vecs++;
        if (oRAM_WR !== 1'b1 || oRAM_RD !== 1'b0 || oRAM_ADDR !== 8'h11 ||
            oRAM_DATA !== 32'h123) begin
            $display("FAIL sw_bus: got wr=%b rd=%b a=%h d=%h want 1 0 11 00000123",
                     oRAM_WR, oRAM_RD, oRAM_ADDR, oRAM_DATA);
            errs++;
        end
        step();
        vecs++;
        if (oRAM_RD !== 1'b1 || oRAM_WR !== 1'b0 || oRAM_ADDR !== 8'h11 ||
            ram[8'h11] !== 32'h123) begin
            $display("FAIL lw_bus: got rd=%b wr=%b a=%h m=%h want 1 0 11 00000123",
                     oRAM_RD, oRAM_WR, oRAM_ADDR, ram[8'h11]);
            errs++;
        end
        step();
        peek(2'b00, 5'd3, v);
        vecs++;
        if (v !== 32'h123) begin
            $display("FAIL lw_x3: got %h want 00000123", v);
            errs++;
        end
    endtask

    task automatic test_branch_jump();
        logic [31:0] v;
        clearRom();
        rom[2] = encB(32'd8, 5'd0, 5'd0, 3'b000);
        rom[3] = addi(5'd5, 5'd0, 32'd1);
        rom[4] = encJ(32'hFFFF_FFF8, 5'd1);
        rom[6] = addi(5'd10, 5'd0, 32'd1);
        rom[7] = encB(32'd8, 5'd0, 5'd1, 3'b100);
        rom[8] = encI(32'd5, 5'd1, 3'b000, 5'd9, 7'b1100111);
        restart();
        step();
        step();
        step();
        peek(2'b01, 5'd0, v);
        vecs++;
        if (v !== 32'd16) begin
            $display("FAIL beq_pc: got %h want 10", v);
            errs++;
        end
        step();
        peek(2'b01, 5'd0, v);
        vecs++;
        if (v !== 32'd8) begin
            $display("FAIL jal_pc: got %h want 8", v);
            errs++;
        end
        peek(2'b00, 5'd1, v);
        vecs++;
        if (v !== 32'd20) begin
            $display("FAIL jal_link: got %h want 14", v);
            errs++;
        end
        rom[2] = encB(32'd8, 5'd0, 5'd0, 3'b001);
        rom[3] = encB(32'd16, 5'd1, 5'd0, 3'b110);
        #1;
        step();
        peek(2'b01, 5'd0, v);
        vecs++;
        if (v !== 32'd12) begin
            $display("FAIL bne_pc: got %h want c", v);
            errs++;
        end
        step();
        peek(2'b01, 5'd0, v);
        vecs++;
        if (v !== 32'd28) begin
            $display("FAIL bltu_pc: got %h want 1c", v);
            errs++;
        end
        step();
        peek(2'b01, 5'd0, v);
        vecs++;
        if (v !== 32'd32) begin
            $display("FAIL blt_pc: got %h want 20", v);
            errs++;
        end
        step();
        peek(2'b01, 5'd0, v);
        vecs++;
        if (v !== 32'd24) begin
            $display("FAIL jalr_pc: got %h want 18", v);
            errs++;
        end
        peek(2'b00, 5'd9, v);
        vecs++;
        if (v !== 32'd36) begin
            $display("FAIL jalr_link: got %h want 24", v);
            errs++;
        end
        peek(2'b00, 5'd5, v);
        vecs++;
        if (v !== 32'd0) begin
            $display("FAIL skipped_x5: got %h want 0", v);
            errs++;
        end
    endtask

    task automatic test_alu_nop();
        logic [31:0] v;
        clearRom();
        rom[0] = addi(5'd0, 5'd0, 32'd9);
        rom[1] = encU(32'hFFFFF, 5'd4, 7'b0110111);
        rom[2] = encI(32'h404, 5'd4, 3'b101, 5'd5, 7'b0010011);
        rom[3] = encS(32'd0, 5'd4, 5'd0, 3'b000);
        rom[4] = addi(5'd6, 5'd0, 32'd3);
        rom[5] = encR(7'b0000000, 5'd6, 5'd4, 3'b010, 5'd7);
        rom[6] = encR(7'b0000000, 5'd6, 5'd4, 3'b011, 5'd8);
        rom[7] = encR(7'b0100000, 5'd4, 5'd6, 3'b000, 5'd9);
        rom[8] = encR(7'b0000000, 5'd6, 5'd4, 3'b101, 5'd10);
        restart();
        step();
        peek(2'b00, 5'd0, v);
        vecs++;
        if (v !== 32'd0) begin
            $display("FAIL x0_write: got %h want 0", v);
            errs++;
        end
        step();
        peek(2'b11, 5'd0, v);
        vecs++;
        if (v !== 32'hFFFF_FF00) begin
            $display("FAIL srai_alu: got %h want ffffff00", v);
            errs++;
        end
        peek(2'b10, 5'd0, v);
        vecs++;
        if (v !== 32'h4042_5293) begin
            $display("FAIL instr_view: got %h want 40425293", v);
            errs++;
        end
        step();
        vecs++;
        if (oRAM_WR !== 1'b0) begin
            $display("FAIL sb_nop_wr: got %b want 0", oRAM_WR);
            errs++;
        end
        step();
        peek(2'b01, 5'd0, v);
        vecs++;
        if (v !== 32'd16 || ram[0] !== 32'd0) begin
            $display("FAIL sb_nop_pc: got %h ram0=%h want 10 0", v, ram[0]);
            errs++;
        end
        for (int i = 0; i < 5; i++) step();
        peek(2'b00, 5'd4, v);
        vecs++;
        if (v !== 32'hFFFF_F000) begin
            $display("FAIL lui_x4: got %h want fffff000", v);
            errs++;
        end
        peek(2'b00, 5'd5, v);
        vecs++;
        if (v !== 32'hFFFF_FF00) begin
            $display("FAIL srai_x5: got %h want ffffff00", v);
            errs++;
        end
        peek(2'b00, 5'd7, v);
        vecs++;
        if (v !== 32'd1) begin
            $display("FAIL slt_x7: got %h want 1", v);
            errs++;
        end
        peek(2'b00, 5'd8, v);
        vecs++;
        if (v !== 32'd0) begin
            $display("FAIL sltu_x8: got %h want 0", v);
            errs++;
        end
        peek(2'b00, 5'd9, v);
        vecs++;
        if (v !== 32'h0000_1003) begin
            $display("FAIL sub_x9: got %h want 00001003", v);
            errs++;
        end
        peek(2'b00, 5'd10, v);
        vecs++;
        if (v !== 32'h1FFF_FE00) begin
            $display("FAIL srl_x10: got %h want 1ffffe00", v);
            errs++;
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] v;
        clearRom();
        for (int i = 0; i < 9; i++)
            rom[i] = addi(5'(i + 1), 5'd0, 32'(i + 1));
        rom[9] = addi(5'd10, 5'd0, 32'd77);
        restart();
        for (int i = 0; i < 9; i++) step();
        peek(2'b01, 5'd0, v);
        vecs++;
        if (v !== 32'h24) begin
            $display("FAIL pre_reset_pc: got %h want 24", v);
            errs++;
        end
        peek(2'b00, 5'd3, v);
        vecs++;
        if (v !== 32'd3) begin
            $display("FAIL pre_reset_x3: got %h want 3", v);
            errs++;
        end
        #1;
        iRST = 1'b1;
        peek(2'b01, 5'd0, v);
        vecs++;
        if (v !== 32'd0 || oROM_ADDR !== 8'd0 || oRAM_CE !== 1'b0) begin
            $display("FAIL async_pc: got %h a=%h ce=%b want 0 00 0", v, oROM_ADDR, oRAM_CE);
            errs++;
        end
        for (int r = 1; r < 32; r++) begin
            peek(2'b00, 5'(r), v);
            vecs++;
            if (v !== 32'd0) begin
                $display("FAIL async_x%0d: got %h want 0", r, v);
                errs++;
            end
        end
        @(negedge iCLK);
        iRST = 1'b0;
        #1;
        vecs++;
        if (oROM_ADDR !== 8'd0 || oROM_CE !== 1'b1) begin
            $display("FAIL post_reset_fetch: got a=%h ce=%b want 00 1", oROM_ADDR, oROM_CE);
            errs++;
        end
        peek(2'b00, 5'd10, v);
        vecs++;
        if (v !== 32'd0) begin
            $display("FAIL aborted_x10: got %h want 0", v);
            errs++;
        end
    endtask

    task automatic test_mul();
        logic [31:0] v;
        logic [31:0] expMul;
`ifdef RISCV32_CPU_MUL_EN
        expMul = 32'd42;
`else
        expMul = 32'd99;
`endif
        clearRom();
        rom[0] = addi(5'd1, 5'd0, 32'd7);
        rom[1] = addi(5'd2, 5'd0, 32'd6);
        rom[2] = addi(5'd6, 5'd0, 32'd99);
        rom[3] = encR(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd6);
        rom[4] = encR(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd7);
        restart();
        for (int i = 0; i < 5; i++) step();
        peek(2'b00, 5'd6, v);
        vecs++;
        if (v !== expMul) begin
            $display("FAIL mul_x6: got %h want %h", v, expMul);
            errs++;
        end
        peek(2'b00, 5'd7, v);
        vecs++;
        if (v !== 32'd13) begin
            $display("FAIL add_x7: got %h want d", v);
            errs++;
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_store();
        test_branch_jump();
        test_alu_nop();
        test_mid_reset();
        test_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
